// File: rtl/tagger_tab_ctrl.sv
// tagger_tab_ctrl: partition-table update controller for the transaction tagger.
// On commit, the decoded configuration is copied into a shadow table one entry per
// cycle. The controller then waits until no tagged transaction is outstanding and
// swaps the shadow table into the active table in a single cycle.
// Optional feature macro: TAGGER_TAB_CHECK_EN. When it is defined, LOAD also runs an
// address-ordering check, and a table that fails the check is rejected.
module tagger_tab_ctrl #(
   parameter int unsigned MAXPARTITION  = 4,
   parameter int unsigned PATID_LEN     = 8,
   parameter int unsigned ADDR_WIDTH    = 34,
   parameter int unsigned OUTSTND_WIDTH = 6
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               commit_i,
   input  logic [MAXPARTITION*ADDR_WIDTH-1:0] cfg_addr_i,
   input  logic [MAXPARTITION*PATID_LEN-1:0]  cfg_patid_i,
   input  logic [MAXPARTITION*2-1:0]          cfg_conf_i,
   input  logic                               txn_issue_i,
   input  logic                               txn_done_i,
   input  logic                               err_clr_i,
   output logic                               commit_clr_o,
   output logic                               hold_o,
   output logic                               busy_o,
   output logic                               err_o,
   output logic [MAXPARTITION*ADDR_WIDTH-1:0] tab_addr_o,
   output logic [MAXPARTITION*PATID_LEN-1:0]  tab_patid_o,
   output logic [MAXPARTITION*2-1:0]          tab_conf_o,
   output logic [7:0]                         tab_epoch_o
);

   localparam int unsigned IDX_W = (MAXPARTITION > 1) ? $clog2(MAXPARTITION) : 1;
   localparam int unsigned TAB_AW = MAXPARTITION * ADDR_WIDTH;
   localparam int unsigned TAB_PW = MAXPARTITION * PATID_LEN;
   localparam int unsigned TAB_CW = MAXPARTITION * 2;
   localparam logic [OUTSTND_WIDTH-1:0] CNT_MAX = {OUTSTND_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_SWAP  = 2'd3
   } state_e;

   state_e                   state_q;
   logic [IDX_W-1:0]         idx_q;
   logic [TAB_AW-1:0]        shd_addr_q;
   logic [TAB_PW-1:0]        shd_patid_q;
   logic [TAB_CW-1:0]        shd_conf_q;
   logic [OUTSTND_WIDTH-1:0] cnt_q;
   logic [OUTSTND_WIDTH-1:0] cnt_nxt;
   logic                     cnt_ovf;
   logic                     cnt_unf;
   logic [ADDR_WIDTH-1:0]    cur_addr;
   logic [PATID_LEN-1:0]     cur_patid;
   logic [1:0]               cur_conf;
   logic                     last_idx;
   logic                     chk_fail;
   logic                     err_set;

`ifdef TAGGER_TAB_CHECK_EN
   logic [ADDR_WIDTH-1:0]    last_addr_q;
   logic                     last_vld_q;
   logic                     chk_fail_q;
`endif

   // State-decoded outputs
   assign busy_o = (state_q != ST_IDLE);
   assign hold_o = (state_q == ST_DRAIN) || (state_q == ST_SWAP);

   // Select the cfg entry addressed by idx
   always_comb begin
      cur_addr  = '0;
      cur_patid = '0;
      cur_conf  = '0;
      for (int unsigned k = 0; k < MAXPARTITION; k++) begin
         if (idx_q == IDX_W'(k)) begin
            cur_addr  = cfg_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            cur_patid = cfg_patid_i[k*PATID_LEN +: PATID_LEN];
            cur_conf  = cfg_conf_i[k*2 +: 2];
         end
      end
   end

   // Ordering check including the entry loaded this cycle
   always_comb begin
`ifdef TAGGER_TAB_CHECK_EN
      chk_fail = chk_fail_q | ((cur_conf != 2'b00) && last_vld_q && (cur_addr <= last_addr_q));
`else
      chk_fail = 1'b0;
`endif
   end

   // Outstanding counter next value and its error conditions
   always_comb begin
      cnt_nxt = cnt_q;
      cnt_ovf = 1'b0;
      cnt_unf = 1'b0;
      if (txn_issue_i && !txn_done_i) begin
         if (cnt_q == CNT_MAX) cnt_ovf = 1'b1;
         else                  cnt_nxt = cnt_q + OUTSTND_WIDTH'(1);
      end else if (txn_done_i && !txn_issue_i) begin
         if (cnt_q == '0) cnt_unf = 1'b1;
         else             cnt_nxt = cnt_q - OUTSTND_WIDTH'(1);
      end
   end

   assign last_idx = (idx_q == IDX_W'(MAXPARTITION - 1));
   assign err_set  = cnt_ovf | cnt_unf | ((state_q == ST_LOAD) && last_idx && chk_fail);

   // Outstanding counter and sticky error flag (set beats clear)
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         err_o <= 1'b0;
      end else begin
         cnt_q <= cnt_nxt;
         err_o <= err_set | (err_o & ~err_clr_i);
      end
   end

   // Update FSM: load shadow, drain, swap into the active table
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         commit_clr_o <= 1'b0;
         shd_addr_q   <= '0;
         shd_patid_q  <= '0;
         shd_conf_q   <= '0;
         tab_addr_o   <= '0;
         tab_patid_o  <= '0;
         tab_conf_o   <= '0;
         tab_epoch_o  <= '0;
`ifdef TAGGER_TAB_CHECK_EN
         last_addr_q  <= '0;
         last_vld_q   <= 1'b0;
         chk_fail_q   <= 1'b0;
`endif
      end else begin
         commit_clr_o <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               idx_q <= '0;
`ifdef TAGGER_TAB_CHECK_EN
               last_addr_q <= '0;
               last_vld_q  <= 1'b0;
               chk_fail_q  <= 1'b0;
`endif
               // commit is still high in the clear-pulse cycle; the register drops it at this edge
               if (commit_i && !commit_clr_o) state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               for (int unsigned k = 0; k < MAXPARTITION; k++) begin
                  if (idx_q == IDX_W'(k)) begin
                     shd_addr_q[k*ADDR_WIDTH +: ADDR_WIDTH] <= cur_addr;
                     shd_patid_q[k*PATID_LEN +: PATID_LEN] <= cur_patid;
                     shd_conf_q[k*2 +: 2]                  <= cur_conf;
                  end
               end
`ifdef TAGGER_TAB_CHECK_EN
               chk_fail_q <= chk_fail;
               if (cur_conf != 2'b00) begin
                  last_addr_q <= cur_addr;
                  last_vld_q  <= 1'b1;
               end
`endif
               idx_q <= idx_q + IDX_W'(1);
               if (last_idx) begin
                  if (chk_fail) begin
                     state_q      <= ST_IDLE;
                     commit_clr_o <= 1'b1;
                  end else begin
                     state_q <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               // Leave as soon as the counter is zero after this cycle's handshakes
               if (cnt_nxt == '0) begin
                  state_q      <= ST_SWAP;
                  commit_clr_o <= 1'b1;
               end
            end
            ST_SWAP: begin
               tab_addr_o  <= shd_addr_q;
               tab_patid_o <= shd_patid_q;
               tab_conf_o  <= shd_conf_q;
               tab_epoch_o <= tab_epoch_o + 8'd1;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/tagger_tab_ctrl.md
# tagger_tab_ctrl

Partition-table update controller for the transaction tagger. It replaces the direct register-to-table copy with a controlled update: it snapshots the decoded partition configuration into a shadow table one entry per cycle, validates it, and waits until no tagged transaction is outstanding. It then swaps the shadow table into the active table in a single cycle. It sits between the tagger register file (reg2hw/hw2reg) and the tagging datapath, and owns the commit-clear handshake back to the register file.

## Interface
- MAXPARTITION, 4, number of partition entries (>=1)
- PATID_LEN, 8, partition-ID width
- ADDR_WIDTH, 34, byte-address width of a partition boundary
- OUTSTND_WIDTH, 6, width of the outstanding-transaction counter
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- commit_i  in  1  commit request (level, from the commit register)
- cfg_addr_i  in  MAXPARTITION*ADDR_WIDTH  decoded boundary address; entry k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- cfg_patid_i  in  MAXPARTITION*PATID_LEN  decoded partition IDs
- cfg_conf_i  in  MAXPARTITION*2  decoded conf per entry; 2'b00 = entry disabled
- txn_issue_i  in  1  one tagged transaction accepted downstream this cycle
- txn_done_i  in  1  one tagged transaction completed this cycle
- err_clr_i  in  1  clears err_o
- commit_clr_o  out  1  one-cycle pulse that clears the commit register (drives de=1, d=0)
- hold_o  out  1  datapath must stop accepting new transactions
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky error flag
- tab_addr_o, tab_patid_o, tab_conf_o  out  same widths as the cfg_* inputs  active table
- tab_epoch_o  out  8  count of completed swaps, wraps at 255→0

## Operation
- States: IDLE, LOAD, DRAIN, SWAP.
- IDLE:
  - commit_i=1 → LOAD.
  - The entry index idx is cleared and the check state is cleared.
- LOAD: one entry per cycle.
  - Copy entry idx from the cfg_* inputs into the shadow table.
  - Run the ordering check on entry idx.
  - idx increments each cycle.
  - After entry MAXPARTITION-1: go to DRAIN if the check passed; otherwise go to IDLE with err_o set and commit_clr_o pulsed, and do not swap.
- Ordering check:
  - Every enabled entry (conf≠0) must have an address strictly greater than the last enabled entry before it.
  - Disabled entries are skipped and do not update the last-enabled address.
  - An empty table (all entries disabled) is legal.
- DRAIN: hold_o=1; move to SWAP in the first cycle in which the outstanding count is 0.
- SWAP (one cycle):
  - hold_o=1 and commit_clr_o=1.
  - At the closing edge: active table ← shadow, tab_epoch_o increments, state → IDLE.
- cfg_* inputs are sampled only during LOAD; changes outside LOAD have no effect.
- Outstanding counter:
  - +1 on txn_issue_i, -1 on txn_done_i; both in the same cycle → unchanged.
  - Issue at the all-ones value: counter saturates and err_o is set.
  - Done at zero: ignored and err_o is set.
  - Issues while hold_o=1 are still counted, because a handshake may complete in the cycle hold_o rises.
- err_o: set by any error source; cleared by err_clr_i. If a set and a clear occur in the same cycle, set wins.

## Timing
- Reset values:
  - Active table all zeros (all entries disabled).
  - tab_epoch_o=0, err_o=0, commit_clr_o=0, hold_o=0, busy_o=0.
  - Counter=0 and state=IDLE.
- Reset during any state aborts the update immediately; the shadow content is discarded.
- Minimum latency, from the first cycle commit_i=1 (cycle 0, in IDLE):
  - LOAD occupies cycles 1..MAXPARTITION.
  - DRAIN occupies cycle MAXPARTITION+1.
  - SWAP occupies cycle MAXPARTITION+2.
  - The new table is visible in cycle MAXPARTITION+3.
- DRAIN has no timeout; it waits indefinitely.
- The commit register clears at the edge ending the commit_clr_o cycle, so IDLE never sees a stale commit.
- commit_i raised while busy_o=1 is ignored until the FSM returns to IDLE.
- All outputs are registered except busy_o and hold_o, which are decoded from the state register.

## Configuration
- TAGGER_TAB_CHECK_EN defined:
  - The ordering check is compiled in.
  - A failing table is rejected as described in Operation.
- Not defined:
  - The check logic is removed.
  - LOAD always proceeds to DRAIN.
  - err_o reflects counter errors only.

## Test plan
- Reset, then MAXPARTITION=4, addr={0x100,0x200,0x300,0x400}, all conf=2'b01, pulse commit_i with the counter at 0 → tab_* updates in cycle 7, tab_epoch_o=1, commit_clr_o high exactly in cycle 6.
- Two txn_issue_i pulses, then commit, then txn_done_i pulses at cycles 10 and 20 → hold_o high from cycle 5, SWAP in cycle 21, new table visible in cycle 22.
- Entry 2 addr=0x150 while entry 1 addr=0x200, both enabled, with TAGGER_TAB_CHECK_EN → err_o=1, commit_clr_o pulses, table and epoch unchanged. The same stimulus without the macro → swap occurs and err_o=0.
- Entry 1 disabled with addr=0 between enabled 0x100 and 0x300 → check passes and the swap occurs.
- Simultaneous txn_issue_i and txn_done_i with the counter at 1 → counter stays at 1. txn_done_i with the counter at 0 → err_o=1; err_clr_i → err_o=0.
- Assert rst_ni low in the middle of DRAIN → all outputs return to reset values. A subsequent commit completes normally with tab_epoch_o=1.
